// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared types and constants for the shift register sequencing controller.
//   state_e  : controller FSM states (StPar exists only with SHIFT_CTRL_PARITY_EN)
//   MODE_*   : register mode encodings, bit order {l, r}
// Optional feature macro: SHIFT_CTRL_PARITY_EN (appends an even-parity beat to every frame).
package shift_ctrl_pkg;

`ifdef SHIFT_CTRL_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_TO0   = 2'b10;  // fill enters bit WIDTH-1
  localparam logic [1:0] MODE_TOMSB = 2'b01;  // fill enters bit 0
  localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if: bundles the producer handshake, the serial consumer handshake and the
// shift register control/data lines of one controller instance.
//   master : controller side (drives in_ready, ser_*, done, sr_l/sr_r/sr_i/sr_d)
//   slave  : environment side (producer, consumer and register)
interface shift_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_msb_first;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_out;
  logic             done;
  logic             sr_l;
  logic             sr_r;
  logic             sr_i;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_q;

  modport master (
    input  in_valid, in_data, in_msb_first, ser_ready, sr_q,
    output in_ready, ser_valid, ser_out, done, sr_l, sr_r, sr_i, sr_d
  );

  modport slave (
    output in_valid, in_data, in_msb_first, ser_ready, sr_q,
    input  in_ready, ser_valid, ser_out, done, sr_l, sr_r, sr_i, sr_d
  );
endinterface

// File: rtl/shift_ctrl_beat_cnt.sv
// shift_ctrl_beat_cnt: beat counter for one frame.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart counting from zero (frame accept)
//   en       : count one beat
//   last     : current count is WIDTH-1 (final data beat)
module shift_ctrl_beat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequencing controller for a 4-mode universal shift register. Accepts a parallel
// word on the in_* handshake, parallel-loads the register, then shifts one bit per accepted
// serial beat, presenting the outgoing bit on ser_out with its own valid/ready handshake.
//   clk, rst     : clock (shared with the register), synchronous active-high reset
//   bus.in_*     : producer handshake, word and bit order (sampled on accept)
//   bus.ser_*    : serial beat handshake and data bit
//   bus.done     : one-cycle pulse on the final beat handshake of a frame
//   bus.sr_*     : register mode {sr_l, sr_r}, fill bit, load data and register outputs
// Optional feature macro: SHIFT_CTRL_PARITY_EN (one even-parity beat after the data beats).
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  shift_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       dir_q;
  logic       accept;
  logic       cnt_en;
  logic       cnt_last;
  logic [1:0] mode;
  logic       in_ready;
  logic       ser_valid;
  logic       ser_out;
  logic       done;
`ifdef SHIFT_CTRL_PARITY_EN
  logic       par_q;
`endif

  assign accept = (state_q == StIdle) && bus.in_valid;
  assign cnt_en = (state_q == StShift) && bus.ser_ready;

  shift_ctrl_beat_cnt #(
    .WIDTH (WIDTH)
  ) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // State register plus the per-frame attributes captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q <= bus.in_msb_first;
`ifdef SHIFT_CTRL_PARITY_EN
        par_q <= ^bus.in_data;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StShift;
      end
      StShift: begin
        if (bus.ser_ready && cnt_last) begin
`ifdef SHIFT_CTRL_PARITY_EN
          state_d = StPar;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      StPar: begin
        if (bus.ser_ready) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Everything is forced idle while rst is high so the register holds its contents.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    done      = 1'b0;
    mode      = MODE_HOLD;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          in_ready = 1'b1;
          if (bus.in_valid) mode = MODE_LOAD;
        end
        StShift: begin
          ser_valid = 1'b1;
          ser_out   = dir_q ? bus.sr_q[WIDTH-1] : bus.sr_q[0];
          if (bus.ser_ready) begin
            mode = dir_q ? MODE_TOMSB : MODE_TO0;
`ifdef SHIFT_CTRL_PARITY_EN
            done = 1'b0;
`else
            done = cnt_last;
`endif
          end
        end
`ifdef SHIFT_CTRL_PARITY_EN
        StPar: begin
          ser_valid = 1'b1;
          ser_out   = par_q;
          done      = bus.ser_ready;
        end
`endif
        default: ;
      endcase
    end
  end

  // Only the end bits of the register are observed; the rest is consumed here to document that.
  logic unused_sr_q;
  assign unused_sr_q = ^bus.sr_q;

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_out   = ser_out;
  assign bus.done      = done;
  assign bus.sr_l      = mode[1];
  assign bus.sr_r      = mode[0];
  assign bus.sr_i      = 1'b0;
  assign bus.sr_d      = bus.in_data;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: self-checking bench for shift_ctrl with an 8-bit 4-mode shift register model.
// A frame-level reference queue of expected beats predicts every handshake output.
// Honours SHIFT_CTRL_PARITY_EN the same way the design does.
module tb_shift_ctrl;

`ifdef SHIFT_CTRL_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(8)) bus ();

  shift_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 8-bit universal shift register, mode {l, r}.
  always @(posedge clk) begin
    case ({bus.sr_l, bus.sr_r})
      2'b10:   bus.sr_q <= {bus.sr_i, bus.sr_q[7:1]};
      2'b01:   bus.sr_q <= {bus.sr_q[6:0], bus.sr_i};
      2'b11:   bus.sr_q <= bus.sr_d;
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference: remaining beats of the current frame, each {is_parity, bit}.
  logic [1:0] exp_q[$];
  logic [7:0] cur_word;
  logic       cur_msb;
  logic [7:0] got_word;
  int         got_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference.
  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic msb,
                      input logic sr);
    logic [1:0] beat;
    int idx;
    @(negedge clk);
    rst             = r;
    bus.in_valid    = iv;
    bus.in_data     = d;
    bus.in_msb_first = msb;
    bus.ser_ready   = sr;
    #1;
    check("sr_i", 32'(bus.sr_i), 32'd0);
    if (r) begin
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mode", 32'({bus.sr_l, bus.sr_r}), 32'd0);
      exp_q.delete();
      got_n = 0;
    end else if (exp_q.size() == 0) begin
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_mode", 32'({bus.sr_l, bus.sr_r}), iv ? 32'd3 : 32'd0);
      if (iv) begin
        check("load_data", 32'(bus.sr_d), 32'(d));
        cur_word = d;
        cur_msb  = msb;
        got_n    = 0;
        got_word = 8'h00;
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, msb ? d[7-k] : d[k]});
        if (ParEn) exp_q.push_back({1'b1, ^d});
      end
    end else begin
      beat = exp_q[0];
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      check("ser_valid", 32'(bus.ser_valid), 32'd1);
      check("ser_out", 32'(bus.ser_out), 32'(beat[0]));
      check("done", 32'(bus.done), 32'(sr && exp_q.size() == 1));
      if (!sr || beat[1]) check("mode_hold", 32'({bus.sr_l, bus.sr_r}), 32'd0);
      else check("mode_shift", 32'({bus.sr_l, bus.sr_r}), cur_msb ? 32'd1 : 32'd2);
      if (sr) begin
        if (!beat[1]) begin
          idx = cur_msb ? 7 - got_n : got_n;
          got_word[idx] = bus.ser_out;
          got_n++;
        end
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) check("frame_word", 32'(got_word), 32'(cur_word));
      end
    end
  endtask

  localparam int NBeats = ParEn ? 9 : 8;

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.in_msb_first = 1'b0;
    bus.ser_ready    = 1'b0;

    // Reset held with a pending word; then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 0xA5 LSB first, consumer always ready.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 0x3C MSB first with 0x81 waiting; 0x81 must be taken right after done.
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Stall for 3 cycles after beat 2.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < NBeats - 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset after beat 4 of 0xFF, then 0x01 LSB first.
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Parity boundary words (plain frames in the default build).
    step(1'b0, 1'b1, 8'h07, 1'b0, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
    for (int i = 0; i < NBeats; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with random backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencing controller for the 8-bit universal shift register (4-mode, mode selected by l/r). Accepts parallel words on a valid/ready handshake, issues the parallel load, then steps the register one shift per accepted beat, presenting the outgoing bit as a serial stream with its own valid/ready handshake. It sits between a byte-wide producer and a bit-serial consumer, and owns all mode, fill-bit and load-data inputs of one register instance.

## Interface
- WIDTH, 8, register width and data bits per frame (2..32)
- clk  in  1  clock, shared with the register's clock input
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word
- in_data  in  WIDTH  word to serialize
- in_msb_first  in  1  bit order, sampled on accept: 0 = LSB first, 1 = MSB first
- ser_valid  out  1  ser_out carries a beat
- ser_ready  in  1  consumer takes the beat
- ser_out  out  1  current serial bit
- done  out  1  one-cycle pulse on the final beat handshake of a frame
- sr_l, sr_r  out  1 each  register mode: 00 hold, 10 shift toward bit 0 (fill enters bit WIDTH-1), 01 shift toward bit WIDTH-1 (fill enters bit 0), 11 parallel load
- sr_i  out  1  fill bit, constant 0
- sr_d  out  WIDTH  parallel load data
- sr_q  in  WIDTH  register outputs

## Operation
- States: IDLE, SHIFT, PAR (PAR only with the parity feature).
- IDLE: in_ready=1, ser_valid=0. sr_d=in_data. If in_valid: mode=11, latch in_msb_first into dir_q, clear beat counter, go to SHIFT; else mode=00.
- SHIFT: ser_valid=1, ser_out = dir_q ? sr_q[WIDTH-1] : sr_q[0].
  - If ser_ready=0: mode=00. ser_out and the counter hold.
  - If ser_ready=1: mode=01 when dir_q, 10 otherwise; counter++.
  - On the handshake with counter==WIDTH-1: go to PAR if enabled, else go to IDLE and pulse done.
- PAR: ser_valid=1, ser_out=par_q, mode=00. On ser_ready: pulse done and go to IDLE.
- Beat counter is $clog2(WIDTH) bits. It never wraps within a frame.
- in_ready=0 outside IDLE. in_valid is ignored there.
- Register contents after a frame are all zero (fill bits); the controller never reads them in IDLE.

## Timing
- Accept cycle (IDLE, in_valid=1) loads the register at the same edge. The first beat is valid the next cycle.
- Throughput, ser_ready held high: one frame per WIDTH+1 cycles (WIDTH+2 with parity).
- All outputs are combinational from state, counter, dir_q, par_q, sr_q and handshake inputs. No output depends combinationally on in_data except sr_d.
- Reset values while rst=1, and in the cycle after release:
  - state=IDLE, counter=0, dir_q=0, par_q=0
  - in_ready=0 while rst=1
  - ser_valid=0, done=0
  - mode=00 forced, so the register holds
- Reset mid-frame: the frame is aborted and no done pulse is issued. The register keeps its contents. in_ready=1 in the first cycle after rst falls.
- ser_ready dropping mid-frame stalls indefinitely with no loss and no duplication.

## Configuration
- SHIFT_CTRL_PARITY_EN defined:
  - par_q = ^in_data is latched on accept (even parity).
  - One extra PAR beat follows the data beats; done moves to that beat.
- Undefined: no PAR state and no par_q. Frames are exactly WIDTH beats.

## Structure
- Package shift_ctrl_pkg holds:
  - the state enum
  - mode constants MODE_HOLD=2'b00, MODE_TO0=2'b10, MODE_TOMSB=2'b01, MODE_LOAD=2'b11, with bit order {l,r}
- One sub-module, shift_ctrl_beat_cnt: counter with clear, enable and a last flag (count==WIDTH-1).
- The bench instantiates the 8-bit shift register and wires sr_* to it.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, mode=00, ser_valid=0. First cycle after release -> in_ready=1.
- 0xA5, LSB first, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept. done on the 8th beat. in_ready=1 on cycle 9.
- 0x3C, MSB first -> ser_out 0,0,1,1,1,1,0,0. A back-to-back second word 0x81 is accepted on the cycle after the first done.
- Stall: 0xA5 LSB first, ser_ready=0 for 3 cycles after beat 2 -> mode=00, ser_out holds 1. The stream resumes 1,0,0,1,0,1 with no duplicated bits.
- Reset after beat 4 of 0xFF -> no done. The next word 0x01 serializes correctly as 1,0,0,0,0,0,0,0.
- With SHIFT_CTRL_PARITY_EN:
  - 0x07 -> 8 data beats, then a 9th beat of 1, with done on the 9th beat.
  - 0x03 -> 9th beat is 0.
